// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one four-phase register-file write port among NREQ sources.
// Latency: grant 1 cycle after req sampled; ack[g] 1 cycle after rf_ack (each +2 with RF_ARB_SYNC_EN).
// Backpressure: ISSUE holds until rf_ack or the TIMEOUT watchdog fires; RELEASE holds until req[g] and rf_ack fall.
// Optional macro RF_ARB_SYNC_EN: 2-flop synchronizers on req and rf_ack.
module rf_write_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255,
  localparam int GW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    ack,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr_w,
  input  logic [NREQ*DW-1:0] data_in,
  output logic               rf_req,
  input  logic               rf_ack,
  output logic               rf_we,
  output logic [AW-1:0]      rf_addr_w,
  output logic [DW-1:0]      rf_data,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Last watchdog count value before the abort fires (counter cleared on grant).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [NREQ-1:0] w_req;
  logic            w_rf_ack;

`ifdef RF_ARB_SYNC_EN
  logic [NREQ-1:0] r_req_s1, r_req_s2;
  logic            r_rf_ack_s1, r_rf_ack_s2;

  // Bring the handshake inputs into clk; payload buses are stable while req is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_s1    <= '0;
      r_req_s2    <= '0;
      r_rf_ack_s1 <= 1'b0;
      r_rf_ack_s2 <= 1'b0;
    end else begin
      r_req_s1    <= req;
      r_req_s2    <= r_req_s1;
      r_rf_ack_s1 <= rf_ack;
      r_rf_ack_s2 <= r_rf_ack_s1;
    end
  end

  assign w_req    = r_req_s2;
  assign w_rf_ack = r_rf_ack_s2;
`else
  assign w_req    = req;
  assign w_rf_ack = rf_ack;
`endif

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   w_pick;
  logic            w_any;
  logic            w_timeout;
  logic [7:0]      r_cnt;
  logic            r_err;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_addr;
  logic [DW-1:0]   r_rf_data;

  // Round-robin pick: first active request scanning upward from r_ptr with wrap.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && w_req[(int'(r_ptr) + k) % NREQ]) begin
        w_any  = 1'b1;
        w_pick = GW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; rf_ack wins over a watchdog expiry in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = we[w_pick] ? S_ISSUE : S_RELEASE;
        end
      end
      S_ISSUE: begin
        if (w_rf_ack) begin
          w_state_nxt = S_RELEASE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_RELEASE;
          w_timeout   = 1'b1;
        end
      end
      S_RELEASE: begin
        // A late rf_ack after a timeout is absorbed here until it falls.
        if (!w_req[r_g] && !w_rf_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant/payload capture, watchdog counter, pointer advance and timeout pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_g       <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_err <= w_timeout;
      if (r_state == S_IDLE && w_any) begin
        r_g       <= w_pick;
        r_rf_we   <= we[w_pick];
        r_rf_addr <= addr_w[int'(w_pick)*AW +: AW];
        r_rf_data <= data_in[int'(w_pick)*DW +: DW];
        r_cnt     <= '0;
      end else if (r_state == S_ISSUE) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == S_RELEASE && w_state_nxt == S_IDLE) begin
        r_ptr <= (r_g == GW'(NREQ - 1)) ? '0 : r_g + 1'b1;
      end
    end
  end

  // Only the current owner sees ack, and only while releasing.
  always_comb begin
    ack = '0;
    if (r_state == S_RELEASE) begin
      ack[r_g] = 1'b1;
    end
  end

  assign rf_req      = (r_state == S_ISSUE);
  assign rf_we       = r_rf_we;
  assign rf_addr_w   = r_rf_addr;
  assign rf_data     = r_rf_data;
  assign grant_id    = r_g;
  assign busy        = (r_state != S_IDLE);
  assign err_timeout = r_err;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter (NREQ=2, DW=16, AW=4, TIMEOUT=8).
// Stimulus pushes expected grants; a negedge monitor pops and compares on each ack rise.
// An RF responder model acks 2 cycles after rf_req unless told to hang for a grant id.
module tb_rf_write_arbiter;

  localparam int TO = 8;
`ifdef RF_ARB_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int gid;
    bit write;
    int addr;
    int data;
    bit tmo;
  } exp_t;

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [15:0] d;
  } pay_t;

  logic        clk, reset_n;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic [1:0]  req, we;
  logic [7:0]  addr_w;
  logic [31:0] data_in;
  logic [1:0]  ack;
  logic        rf_req, rf_ack, rf_we;
  logic [3:0]  rf_addr_w;
  logic [15:0] rf_data;
  logic [0:0]  grant_id;
  logic        busy, err_timeout;

  assign req     = {req1, req0};
  assign we      = {we1, we0};
  assign addr_w  = {addr1, addr0};
  assign data_in = {data1, data0};

  rf_write_arbiter #(.NREQ(2), .DW(16), .AW(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .we(we),
    .addr_w(addr_w), .data_in(data_in), .rf_req(rf_req), .rf_ack(rf_ack),
    .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data(rf_data),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_rfack = 0;
  int   rf_hang_gid = -1;
  exp_t sb[$];
  pay_t pq0[$], pq1[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait on negedges for a condition: 0 rf_req, 1 ack[0], 2 ack[1], else !busy.
  task automatic wait_neg(input int which, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      case (which)
        0:       ok = rf_req;
        1:       ok = ack[0];
        2:       ok = ack[1];
        default: ok = !busy;
      endcase
    end
    chk(name, ok, 1);
  endtask

  // Cycle-based four-phase requesters fed from pq0/pq1.
  task automatic run_driver(input int budget);
    bit   done;
    pay_t p;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk); #1;
      if (req0 && ack[0]) req0 = 1'b0;
      else if (!req0 && !ack[0] && pq0.size() > 0) begin
        p = pq0.pop_front(); we0 = p.w; addr0 = p.a; data0 = p.d; req0 = 1'b1;
      end
      if (req1 && ack[1]) req1 = 1'b0;
      else if (!req1 && !ack[1] && pq1.size() > 0) begin
        p = pq1.pop_front(); we1 = p.w; addr1 = p.a; data1 = p.d; req1 = 1'b1;
      end
      done = !req0 && !req1 && pq0.size() == 0 && pq1.size() == 0 && !busy;
    end
    chk("driver_done", done, 1);
  endtask

  // RF model: ack 2 cycles after rf_req is seen, drop after rf_req falls.
  initial begin
    rf_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && rf_req && int'(grant_id) != rf_hang_gid) begin
        repeat (2) @(posedge clk);
        #1 rf_ack = 1'b1;
        t_rfack = cyc;
        for (int n = 0; n < 1000; n++) begin
          @(negedge clk);
          if (!rf_req || !reset_n) break;
        end
        @(posedge clk);
        #1 rf_ack = 1'b0;
      end
    end
  end

  // Monitor: checks RF payload while rf_req is high, pops one expectation per ack rise.
  initial begin
    bit         prev_rf, prev_err, seen_rf;
    logic [1:0] prev_ack;
    int         err_cnt, rf_cyc, err_cyc;
    exp_t       e;
    prev_rf = 0; prev_err = 0; seen_rf = 0; prev_ack = '0;
    err_cnt = 0; rf_cyc = 0; err_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_rf = 0; prev_err = 0; seen_rf = 0; prev_ack = '0; err_cnt = 0;
      end else begin
        if (err_timeout) begin
          chk("err_single_cycle", int'(prev_err), 0);
          err_cnt++;
          err_cyc = cyc;
        end
        if (rf_req && !prev_rf) begin
          seen_rf = 1;
          rf_cyc  = cyc;
          chk("rf_req_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            chk("rf_req_for_write", int'(sb[0].write), 1);
            chk("rf_we", int'(rf_we), 1);
            chk("rf_grant_id", int'(grant_id), sb[0].gid);
          end
        end
        if (rf_req && sb.size() > 0) begin
          chk("rf_addr_w", int'(rf_addr_w), sb[0].addr);
          chk("rf_data", int'(rf_data), sb[0].data);
        end
        if (ack != 2'b00) chk("ack_onehot", $countones(ack), 1);
        if (ack != 2'b00 && prev_ack == 2'b00) begin
          chk("ack_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ack_vector", int'(ack), 1 << e.gid);
            chk("ack_grant_id", int'(grant_id), e.gid);
            chk("rf_txn_seen", int'(seen_rf), int'(e.write));
            chk("err_pulses", err_cnt, e.tmo ? 1 : 0);
            if (e.tmo) chk("timeout_latency", err_cyc - rf_cyc, TO);
          end
          seen_rf = 0;
          err_cnt = 0;
        end
        prev_rf  = rf_req;
        prev_err = err_timeout;
        prev_ack = ack;
      end
    end
  end

  initial begin
    int t0;
    reset_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;

    // Reset values.
    #2;
    chk("rst_rf_req", int'(rf_req), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_rf_payload", int'({rf_we, rf_addr_w, rf_data}), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single write from requester 0.
    @(posedge clk); #1;
    we0 = 1; addr0 = 4'h3; data0 = 16'hBEEF; req0 = 1;
    sb.push_back('{0, 1'b1, 'h3, 'hBEEF, 1'b0});
    t0 = cyc;
    wait_neg(0, 20, "wait_rf_req_single");
    chk("lat_req_to_rf_req", cyc - t0, LAT);
    wait_neg(1, 40, "wait_ack0_single");
    chk("lat_rf_ack_to_ack", cyc - t_rfack, LAT);
    @(posedge clk); #1 req0 = 0;
    wait_neg(3, 40, "wait_idle_single");

    // Contention: ptr is 1 after the single write, so grants go 1,0,1,0.
    pq0.push_back('{1'b1, 4'hA, 16'hA0A0});
    pq0.push_back('{1'b1, 4'hB, 16'hB0B0});
    pq1.push_back('{1'b1, 4'hC, 16'hC0C0});
    pq1.push_back('{1'b1, 4'hD, 16'hD0D0});
    sb.push_back('{1, 1'b1, 'hC, 'hC0C0, 1'b0});
    sb.push_back('{0, 1'b1, 'hA, 'hA0A0, 1'b0});
    sb.push_back('{1, 1'b1, 'hD, 'hD0D0, 1'b0});
    sb.push_back('{0, 1'b1, 'hB, 'hB0B0, 1'b0});
    run_driver(400);

    // No-write request from requester 1.
    @(posedge clk); #1;
    we1 = 0; addr1 = 4'h9; data1 = 16'h1234; req1 = 1;
    sb.push_back('{1, 1'b0, 'h9, 'h1234, 1'b0});
    t0 = cyc;
    wait_neg(2, 20, "wait_ack1_nowrite");
    chk("lat_nowrite_ack", cyc - t0, LAT);
    @(posedge clk); #1 req1 = 0;
    wait_neg(3, 40, "wait_idle_nowrite");

    // Timeout on requester 0 (ptr now 0), then requester 1 served normally.
    rf_hang_gid = 0;
    pq0.push_back('{1'b1, 4'h5, 16'h5555});
    pq1.push_back('{1'b1, 4'h6, 16'h6666});
    sb.push_back('{0, 1'b1, 'h5, 'h5555, 1'b1});
    sb.push_back('{1, 1'b1, 'h6, 'h6666, 1'b0});
    run_driver(400);
    rf_hang_gid = -1;

    // Move ptr to 1, then reset while requester 1 is in ISSUE.
    pq0.push_back('{1'b1, 4'h7, 16'h7777});
    sb.push_back('{0, 1'b1, 'h7, 'h7777, 1'b0});
    run_driver(200);
    rf_hang_gid = 1;
    @(posedge clk); #1;
    we1 = 1; addr1 = 4'h8; data1 = 16'h8888; req1 = 1;
    sb.push_back('{1, 1'b1, 'h8, 'h8888, 1'b0});
    wait_neg(0, 20, "wait_rf_req_hang");
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_rf_req", int'(rf_req), 0);
    chk("midrst_ack", int'(ack), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_grant_id", int'(grant_id), 0);
    chk("midrst_rf_addr_w", int'(rf_addr_w), 0);
    chk("midrst_rf_data", int'(rf_data), 0);
    sb.delete();
    req1 = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rf_hang_gid = -1;

    // After reset ptr is 0 again: requester 0 wins a simultaneous request.
    pq0.push_back('{1'b1, 4'h1, 16'h1111});
    pq1.push_back('{1'b1, 4'h2, 16'h2222});
    sb.push_back('{0, 1'b1, 'h1, 'h1111, 1'b0});
    sb.push_back('{1, 1'b1, 'h2, 'h2222, 1'b0});
    run_driver(400);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
